// File: rtl/core_seq_ctrl_if.sv
// Control/status bundle between the attention-core sequencer and the datapath it steers.
// The sequencer takes the master view; the datapath or a bench takes the slave view.
interface core_seq_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              vn_mode;
    logic [ADDR_W:0]   len_k;
    logic [ADDR_W:0]   len_q;
    logic              fifo_valid;
    logic              fifo_rd;
    logic [ADDR_W-1:0] qk_add;
    logic              qmem_rd;
    logic              kmem_rd;
    logic [1:0]        mac_inst;
    logic              pmem_wr;
    logic [ADDR_W-1:0] pmem_add;
    logic              sfp_acc;
    logic              sfp_div;
    logic              busy;
    logic              done;

    modport master (
        input  start, vn_mode, len_k, len_q, fifo_valid,
        output fifo_rd, qk_add, qmem_rd, kmem_rd, mac_inst,
               pmem_wr, pmem_add, sfp_acc, sfp_div, busy, done
    );

    modport slave (
        output start, vn_mode, len_k, len_q, fifo_valid,
        input  fifo_rd, qk_add, qmem_rd, kmem_rd, mac_inst,
               pmem_wr, pmem_add, sfp_acc, sfp_div, busy, done
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// Attention-core sequencer: one start runs kernel load, query stream and an ofifo drain
// to pmem, either raw (VN) or through the sfp normaliser on a fixed per-row slot (QK).
module core_seq_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int SFP_CYC   = 8,
    parameter int ACC_AT    = 1,
    parameter int DIV_FIRST = 3,
    parameter int DIV_LAST  = 4,
    parameter int WB_AT     = 5
) (
    input  logic           clk,
    input  logic           reset,
    core_seq_ctrl_if.master bus
);
    localparam int SW = $clog2(SFP_CYC);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SFP_CYC - 1);
    localparam logic [SW-1:0] SLOT_ACC  = SW'(ACC_AT);
    localparam logic [SW-1:0] SLOT_DIV0 = SW'(DIV_FIRST);
    localparam logic [SW-1:0] SLOT_DIV1 = SW'(DIV_LAST);
    localparam logic [SW-1:0] SLOT_WB   = SW'(WB_AT);

    typedef enum logic [2:0] {IDLE, LOAD_K, EXEC, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              vnMode_q, vnMode_d;
    logic [ADDR_W:0]   lenK_q, lenK_d;
    logic [ADDR_W:0]   lenQ_q, lenQ_d;
    logic [ADDR_W:0]   addrCnt_q, addrCnt_d;
    logic [ADDR_W:0]   rowCnt_q, rowCnt_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [ADDR_W-1:0] slotRow_q, slotRow_d;
    logic [ADDR_W-1:0] qkAdd_q, qkAdd_d;
    logic              qmemRd_q, qmemRd_d;
    logic              kmemRd_q, kmemRd_d;
    logic [1:0]        macInst_q, macInst_d;
    logic              pmemWr_q, pmemWr_d;
    logic [ADDR_W-1:0] pmemAdd_q, pmemAdd_d;
    logic              sfpAcc_q, sfpAcc_d;
    logic              sfpDiv_q, sfpDiv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drainAct;
    logic              popNow;
    logic              lastWr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            vnMode_q  <= 1'b0;
            lenK_q    <= '0;
            lenQ_q    <= '0;
            addrCnt_q <= '0;
            rowCnt_q  <= '0;
            slot_q    <= '0;
            slotRow_q <= '0;
            qkAdd_q   <= '0;
            qmemRd_q  <= 1'b0;
            kmemRd_q  <= 1'b0;
            macInst_q <= 2'b00;
            pmemWr_q  <= 1'b0;
            pmemAdd_q <= '0;
            sfpAcc_q  <= 1'b0;
            sfpDiv_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vnMode_q  <= vnMode_d;
            lenK_q    <= lenK_d;
            lenQ_q    <= lenQ_d;
            addrCnt_q <= addrCnt_d;
            rowCnt_q  <= rowCnt_d;
            slot_q    <= slot_d;
            slotRow_q <= slotRow_d;
            qkAdd_q   <= qkAdd_d;
            qmemRd_q  <= qmemRd_d;
            kmemRd_q  <= kmemRd_d;
            macInst_q <= macInst_d;
            pmemWr_q  <= pmemWr_d;
            pmemAdd_q <= pmemAdd_d;
            sfpAcc_q  <= sfpAcc_d;
            sfpDiv_q  <= sfpDiv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        state_d   = state_q;
        vnMode_d  = vnMode_q;
        lenK_d    = lenK_q;
        lenQ_d    = lenQ_q;
        addrCnt_d = addrCnt_q;
        rowCnt_d  = rowCnt_q;
        slot_d    = slot_q;
        slotRow_d = slotRow_q;
        qkAdd_d   = '0;
        qmemRd_d  = 1'b0;
        kmemRd_d  = 1'b0;
        macInst_d = {qmemRd_q, kmemRd_q};
        popNow    = 1'b0;
        lastWr    = 1'b0;
        drainAct  = (state_q == EXEC) || (state_q == DRAIN);

        if (drainAct) begin
            if (vnMode_q) begin
                popNow = bus.fifo_valid && (rowCnt_q < lenQ_q);
                lastWr = popNow && (rowCnt_q == lenQ_q - 1'b1);
            end else begin
                if (slot_q == '0) begin
                    popNow = bus.fifo_valid && (rowCnt_q < lenQ_q);
                    if (popNow) begin
                        slot_d    = {{(SW-1){1'b0}}, 1'b1};
                        slotRow_d = rowCnt_q[ADDR_W-1:0];
                    end
                end else begin
                    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
                end
                lastWr = pmemWr_q && ({1'b0, slotRow_q} == lenQ_q - 1'b1);
            end
            if (popNow) begin
                rowCnt_d = rowCnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                rowCnt_d = '0;
                slot_d   = '0;
                if (bus.start) begin
                    vnMode_d = bus.vn_mode;
                    lenK_d   = bus.len_k;
                    lenQ_d   = bus.len_q;
                    if ((bus.len_k == '0) || (bus.len_q == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d   = LOAD_K;
                        kmemRd_d  = 1'b1;
                        addrCnt_d = {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
            end
            LOAD_K: begin
                if (addrCnt_q == lenK_q) begin
                    state_d   = EXEC;
                    qmemRd_d  = 1'b1;
                    addrCnt_d = {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    kmemRd_d  = 1'b1;
                    qkAdd_d   = addrCnt_q[ADDR_W-1:0];
                    addrCnt_d = addrCnt_q + 1'b1;
                end
            end
            EXEC: begin
                if (addrCnt_q == lenQ_q) begin
                    state_d = DRAIN;
                end else begin
                    qmemRd_d  = 1'b1;
                    qkAdd_d   = addrCnt_q[ADDR_W-1:0];
                    addrCnt_d = addrCnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // A VN drain can finish while the query stream is still running.
                if (lastWr || (vnMode_q && (rowCnt_q == lenQ_q))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                addrCnt_d = '0;
                rowCnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != EXEC) && (state_d != DRAIN)) begin
            slot_d = '0;
        end

        sfpAcc_d  = !vnMode_q && (slot_d == SLOT_ACC);
        sfpDiv_d  = !vnMode_q && (slot_d >= SLOT_DIV0) && (slot_d <= SLOT_DIV1);
        pmemWr_d  = !vnMode_q && (slot_d == SLOT_WB);
        pmemAdd_d = pmemWr_d ? slotRow_q : '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    assign bus.fifo_rd  = popNow;
    assign bus.qk_add   = qkAdd_q;
    assign bus.qmem_rd  = qmemRd_q;
    assign bus.kmem_rd  = kmemRd_q;
    assign bus.mac_inst = macInst_q;
    assign bus.pmem_wr  = vnMode_q ? popNow : pmemWr_q;
    assign bus.pmem_add = vnMode_q ? rowCnt_q[ADDR_W-1:0] : pmemAdd_q;
    assign bus.sfp_acc  = sfpAcc_q;
    assign bus.sfp_div  = sfpDiv_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: runs whole passes, logs strobes per cycle on the
// falling edge and compares the logs against hand-derived sequences and timings.
module tb_core_seq_ctrl;
    logic clk;
    logic reset;

    core_seq_ctrl_if #(.ADDR_W(4)) bus ();

    core_seq_ctrl #(
        .ADDR_W(4), .SFP_CYC(8), .ACC_AT(1), .DIV_FIRST(3), .DIV_LAST(4), .WB_AT(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int failures;
    int cyc;
    int startCyc;
    bit logClear;
    int busyCnt;
    int wrNoValid;
    int kAddr[$], kCyc[$], qAddr[$], qCyc[$], mac01Cyc[$], mac10Cyc[$];
    int pAddr[$], wrCyc[$], popCyc[$], accCyc[$], divCyc[$], doneCyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Falling-edge monitor: every strobe is logged with the cycle number it appeared in.
    always @(negedge clk) begin
        if (logClear) begin
            kAddr.delete(); kCyc.delete(); qAddr.delete(); qCyc.delete();
            mac01Cyc.delete(); mac10Cyc.delete(); pAddr.delete(); wrCyc.delete();
            popCyc.delete(); accCyc.delete(); divCyc.delete(); doneCyc.delete();
            busyCnt   = 0;
            wrNoValid = 0;
        end else begin
            if (bus.kmem_rd) begin kAddr.push_back(int'(bus.qk_add)); kCyc.push_back(cyc); end
            if (bus.qmem_rd) begin qAddr.push_back(int'(bus.qk_add)); qCyc.push_back(cyc); end
            if (bus.mac_inst == 2'b01) mac01Cyc.push_back(cyc);
            if (bus.mac_inst == 2'b10) mac10Cyc.push_back(cyc);
            if (bus.pmem_wr) begin pAddr.push_back(int'(bus.pmem_add)); wrCyc.push_back(cyc); end
            if (bus.pmem_wr && bus.vn_mode && !bus.fifo_valid) wrNoValid++;
            if (bus.fifo_rd) popCyc.push_back(cyc);
            if (bus.sfp_acc) accCyc.push_back(cyc);
            if (bus.sfp_div) divCyc.push_back(cyc);
            if (bus.done) doneCyc.push_back(cyc);
            if (bus.busy) busyCnt++;
        end
        cyc++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int outsVec();
        logic [17:0] v;
        v = {bus.fifo_rd, bus.qk_add, bus.qmem_rd, bus.kmem_rd, bus.mac_inst, bus.pmem_wr,
             bus.pmem_add, bus.sfp_acc, bus.sfp_div, bus.busy, bus.done};
        return int'(v);
    endfunction

    // One pass: optional valid toggling, stray start pulses, or a reset at loop step resetAt.
    task automatic applyStimulus(input bit vn, input int lk, input int lq, input bit togg,
                                 input bit pokeStart, input int resetAt);
        bit seen;
        bit aborted;
        seen    = 1'b0;
        aborted = 1'b0;
        @(posedge clk); #1;
        logClear = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        logClear    = 1'b0;
        bus.vn_mode = vn;
        bus.len_k   = 5'(lk);
        bus.len_q   = 5'(lq);
        bus.start   = 1'b1;
        startCyc    = cyc;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (reset) begin
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            bus.start      = pokeStart && (n == 1 || n == 5 || n == 15);
            bus.fifo_valid = togg ? n[0] : 1'b1;
            if (n == resetAt) reset = 1'b1;
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        if (!seen && !aborted) checkOutput("timeout", 0, 1);
        if (seen) begin
            @(negedge clk);
            checkOutput("busyAfter", int'(bus.busy), 0);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        cyc            = 0;
        logClear       = 1'b0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.vn_mode    = 1'b0;
        bus.len_k      = '0;
        bus.len_q      = '0;
        bus.fifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstOuts", outsVec(), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] VN pass, len_k=8 len_q=8");
        applyStimulus(1'b1, 8, 8, 1'b0, 1'b0, -1);
        checkOutput("vnKCount", kAddr.size(), 8);
        checkOutput("vnKFirstCyc", kCyc[0], startCyc + 1);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("vnKAddr%0d", i), kAddr[i], i);
        checkOutput("vnMac01Count", mac01Cyc.size(), 8);
        checkOutput("vnMac01First", mac01Cyc[0], kCyc[0] + 1);
        checkOutput("vnMac01Last", mac01Cyc[7], kCyc[7] + 1);
        checkOutput("vnQBackToBack", qCyc[0], kCyc[7] + 1);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("vnQAddr%0d", i), qAddr[i], i);
        checkOutput("vnMac10Count", mac10Cyc.size(), 8);
        checkOutput("vnMac10First", mac10Cyc[0], qCyc[0] + 1);
        checkOutput("vnWrCount", pAddr.size(), 8);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("vnPAddr%0d", i), pAddr[i], i);
        checkOutput("vnDoneCount", doneCyc.size(), 1);
        checkOutput("vnBusyCycles", busyCnt, doneCyc[0] - startCyc);

        $display("[TB] QK pass, len_k=8 len_q=4");
        applyStimulus(1'b0, 8, 4, 1'b0, 1'b0, -1);
        checkOutput("qkPopCount", popCyc.size(), 4);
        checkOutput("qkFirstPop", popCyc[0], qCyc[0]);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("qkPop%0d", i), popCyc[i], popCyc[0] + 8 * i);
            checkOutput($sformatf("qkAcc%0d", i), accCyc[i], popCyc[i] + 1);
            checkOutput($sformatf("qkDivA%0d", i), divCyc[2 * i], popCyc[i] + 3);
            checkOutput($sformatf("qkDivB%0d", i), divCyc[2 * i + 1], popCyc[i] + 4);
            checkOutput($sformatf("qkWr%0d", i), wrCyc[i], popCyc[i] + 5);
            checkOutput($sformatf("qkPAddr%0d", i), pAddr[i], i);
        end
        checkOutput("qkWrCount", pAddr.size(), 4);
        checkOutput("qkDone", doneCyc[0], wrCyc[3] + 1);

        $display("[TB] VN pass with toggling fifo_valid");
        applyStimulus(1'b1, 2, 6, 1'b1, 1'b0, -1);
        checkOutput("togWrCount", pAddr.size(), 6);
        checkOutput("togWrNoValid", wrNoValid, 0);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("togPAddr%0d", i), pAddr[i], i);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("togGap%0d", i), wrCyc[i + 1], wrCyc[i] + 2);

        $display("[TB] reset on third EXEC cycle");
        applyStimulus(1'b1, 4, 8, 1'b0, 1'b0, 6);
        @(negedge clk);
        checkOutput("abortOuts", outsVec(), 0);
        checkOutput("abortWrBefore", pAddr.size(), 3);
        repeat (4) @(negedge clk);
        checkOutput("abortNoDone", doneCyc.size(), 0);
        applyStimulus(1'b1, 4, 4, 1'b0, 1'b0, -1);
        checkOutput("restartWrCount", pAddr.size(), 4);
        checkOutput("restartLastAddr", pAddr[3], 3);
        checkOutput("restartDone", doneCyc.size(), 1);

        $display("[TB] stray start pulses while busy");
        applyStimulus(1'b0, 4, 4, 1'b0, 1'b1, -1);
        checkOutput("pokeKCount", kAddr.size(), 4);
        checkOutput("pokeWrCount", pAddr.size(), 4);
        checkOutput("pokeDone", doneCyc.size(), 1);
        repeat (4) @(negedge clk);
        checkOutput("pokeNoRestart", kAddr.size(), 4);

        $display("[TB] start with len_q=0");
        applyStimulus(1'b1, 8, 0, 1'b0, 1'b0, -1);
        checkOutput("zeroDoneCyc", doneCyc[0], startCyc + 1);
        checkOutput("zeroDoneCount", doneCyc.size(), 1);
        checkOutput("zeroKRd", kAddr.size(), 0);
        checkOutput("zeroQRd", qAddr.size(), 0);
        checkOutput("zeroWr", pAddr.size(), 0);
        checkOutput("zeroPop", popCyc.size(), 0);

        $display("[TB] full depth, len_k=len_q=16");
        applyStimulus(1'b1, 16, 16, 1'b0, 1'b0, -1);
        checkOutput("fullKCount", kAddr.size(), 16);
        checkOutput("fullKLast", kAddr[15], 15);
        checkOutput("fullQCount", qAddr.size(), 16);
        checkOutput("fullQLast", qAddr[15], 15);
        checkOutput("fullWrCount", pAddr.size(), 16);
        checkOutput("fullWrFirst", pAddr[0], 0);
        checkOutput("fullWrLast", pAddr[15], 15);
        checkOutput("fullDone", doneCyc.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
